// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin packet arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MAX_CYCLES = 64;

    // Width needed to hold values 0..n-1, never less than one bit so that
    // single-entry configurations still get a legal vector.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req scanning upward from ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is set.
// Ports: req (requests), ptr (start index, must be < N), onehot/idx (winner), any (winner valid).
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // One guard bit so ptr + offset (at most 2N-2) never overflows before
    // the single wrap subtraction.
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            cand = sum[PTR_W-1:0];
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin, packet-locked arbiter + mux sharing one output port among N_REQ requesters.
// Latency: grant one cycle after request; datapath through the granted lane is combinational.
// Backpressure: i_ready passes straight to the granted o_ready bit; grant held until last beat or watchdog.
// Ports: clk/reset (sync, active-high); i_req/i_valid/i_last/i_data per requester; o_ready/o_gnt per
//        requester; o_valid/o_last/o_data/i_ready on the output link; o_busy, o_timeout status.
module rr_packet_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_valid,
    input  logic [N_REQ-1:0]        i_last,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_ready,
    output logic [N_REQ-1:0]        o_gnt,
    output logic                    o_valid,
    output logic                    o_last,
    output logic [DATA_W-1:0]       o_data,
    input  logic                    i_ready,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam int PTR_W = idx_width(N_REQ);
    localparam int CNT_W = idx_width(MAX_CYCLES);

    arb_state_t       state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [PTR_W-1:0] gnt_idx, gnt_idx_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [PTR_W-1:0] rel_ptr, pick_ptr, pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             pick_any;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_nxt;
    logic             busy;
    logic             rel_done, rel_force, rel;

    assign busy   = (state == BUSY);
    assign o_busy = busy;

    // Output mux keyed on the one-hot grant: with no grant every output
    // collapses to zero without a separate idle case.
    always_comb begin
        o_valid = |(i_valid & o_gnt);
        o_last  = |(i_last & o_gnt);
        o_ready = o_gnt & {N_REQ{i_ready}};
        o_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (o_gnt[k]) begin
                o_data = o_data | i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Release conditions. A last beat that transfers wins over the watchdog
    // in the same cycle, so o_timeout only flags packets that were cut short.
    assign rel_done  = o_valid && i_ready && o_last;
    assign rel_force = busy && !rel_done && (cnt == CNT_W'(MAX_CYCLES - 1));
    assign rel       = rel_done || rel_force;

    // Pointer one past the current owner; the picker uses it directly on a
    // release edge so the next packet is granted with no idle bubble.
    assign rel_ptr  = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign pick_ptr = busy ? rel_ptr : ptr;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (i_req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = o_gnt;
        gnt_idx_nxt = gnt_idx;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt   = BUSY;
                    gnt_nxt     = pick_onehot;
                    gnt_idx_nxt = pick_idx;
                    cnt_nxt     = '0;
                end
            end
            BUSY: begin
                // Counts every owned cycle; the watchdog fires before it can wrap.
                cnt_nxt = cnt + 1'b1;
                if (rel) begin
                    ptr_nxt     = rel_ptr;
                    timeout_nxt = rel_force;
                    cnt_nxt     = '0;
                    if (pick_any) begin
                        gnt_nxt     = pick_onehot;
                        gnt_idx_nxt = pick_idx;
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            o_gnt     <= '0;
            gnt_idx   <= '0;
            ptr       <= '0;
            cnt       <= '0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_gnt     <= gnt_nxt;
            gnt_idx   <= gnt_idx_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            o_timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Self-checking bench for rr_packet_arbiter: directed scenarios plus random traffic vs. a reference model.
// Latency: n/a.
// Backpressure: i_ready driven directly by the bench.
module tb_rr_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MC = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    i_req, i_valid, i_last;
    logic [N*DW-1:0] i_data;
    logic            i_ready;
    logic [N-1:0]    o_ready, o_gnt;
    logic            o_valid, o_last, o_busy, o_timeout;
    logic [DW-1:0]   o_data;

    always #5 clk = ~clk;

    rr_packet_arbiter #(
        .N_REQ      (N),
        .DATA_W     (DW),
        .MAX_CYCLES (MC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_valid   (i_valid),
        .i_last    (i_last),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_gnt     (o_gnt),
        .o_valid   (o_valid),
        .o_last    (o_last),
        .o_data    (o_data),
        .i_ready   (i_ready),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the port (-1 = nobody), where the next
    // search starts, how long the owner has held it, and the timeout flag.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_tout  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int k);
        logic [N-1:0] t;
        t = v >> k;
        return t[0];
    endfunction

    // Round-robin search: first requester at or after 'from', wrapping.
    function automatic int rr_search(input logic [N-1:0] req, input int from);
        for (int i = 0; i < N; i++) begin
            if (bit_of(req, (from + i) % N)) return (from + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] lane(input int k, input int beat);
        return DW'((k << 16) | beat);
    endfunction

    task automatic model_step();
        bit done;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_tout  = 1'b0;
        end else begin
            m_tout = 1'b0;
            if (m_owner < 0) begin
                m_owner = rr_search(i_req, m_ptr);
                m_hold  = 0;
            end else begin
                done = bit_of(i_valid, m_owner) && i_ready && bit_of(i_last, m_owner);
                if (done || m_hold == MC - 1) begin
                    m_tout  = !done;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = rr_search(i_req, m_ptr);
                    m_hold  = 0;
                end else begin
                    m_hold++;
                end
            end
        end
    endtask

    // Compare every output against the model for the inputs currently
    // applied, then advance one clock. Entered and left just after a negedge.
    task automatic tick();
        logic [N-1:0]    eg;
        logic [N*DW-1:0] sh;
        logic [DW-1:0]   ed;
        bit              ev, el;
        #1;
        eg = '0; ed = '0; ev = 1'b0; el = 1'b0;
        if (m_owner >= 0) begin
            eg = N'(1) << m_owner;
            sh = i_data >> (m_owner * DW);
            ed = sh[DW-1:0];
            ev = bit_of(i_valid, m_owner);
            el = bit_of(i_last, m_owner);
        end
        chk("gnt",     o_gnt,     eg);
        chk("busy",    o_busy,    m_owner >= 0);
        chk("valid",   o_valid,   ev);
        chk("last",    o_last,    el);
        chk("data",    o_data,    ed);
        chk("ready",   o_ready,   i_ready ? eg : '0);
        chk("timeout", o_timeout, m_tout);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input logic [N-1:0] req, input logic [N-1:0] valid,
                          input logic [N-1:0] last, input logic rdy, input int beat);
        i_req   = req;
        i_valid = valid;
        i_last  = last;
        i_ready = rdy;
        for (int k = 0; k < N; k++) i_data[k*DW +: DW] = lane(k, beat);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in('0, '0, '0, 1'b0, 0);
        tick();
        reset = 1'b0;
    endtask

    logic [N-1:0] fair_seq [5];

    initial begin
        fair_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1;
        set_in('0, '0, '0, 1'b0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        do_reset();
        #1;
        chk("rst_gnt",  o_gnt,  4'b0000);
        chk("rst_busy", o_busy, 1'b0);

        // Single requester, 3-beat packet
        do_reset();
        set_in(4'b0100, '0, '0, 1'b1, 0);
        #1 chk("s1_gnt_req_cycle", o_gnt, 4'b0000);
        tick();
        for (int b = 0; b < 3; b++) begin
            set_in((b == 2) ? 4'b0000 : 4'b0100, 4'b0100, (b == 2) ? 4'b0100 : 4'b0000, 1'b1, b);
            #1;
            chk("s1_gnt",  o_gnt,  4'b0100);
            chk("s1_data", o_data, lane(2, b));
            tick();
        end
        set_in('0, '0, '0, 1'b1, 0);
        #1;
        chk("s1_gnt_after",  o_gnt,  4'b0000);
        chk("s1_busy_after", o_busy, 1'b0);
        tick();

        // Fairness with everyone requesting single-beat packets
        do_reset();
        set_in(4'b1111, 4'b1111, 4'b1111, 1'b1, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s2_fair_gnt",   o_gnt,   fair_seq[i]);
            chk("s2_fair_valid", o_valid, 1'b1);
            tick();
        end

        // Backpressure on a last beat
        do_reset();
        set_in(4'b0010, 4'b0010, 4'b0010, 1'b0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s3_ready_bp", o_ready, 4'b0000);
            chk("s3_gnt_held", o_gnt,   4'b0010);
            tick();
        end
        set_in(4'b0000, 4'b0010, 4'b0010, 1'b1, 0);
        #1 chk("s3_ready_go", o_ready, 4'b0010);
        tick();
        set_in('0, '0, '0, 1'b1, 0);
        #1 chk("s3_gnt_released", o_gnt, 4'b0000);
        tick();

        // Watchdog: requester 2 never sends last
        do_reset();
        set_in(4'b1100, 4'b0100, 4'b0000, 1'b1, 0);
        tick();
        for (int c = 0; c < MC; c++) begin
            #1;
            chk("s4_gnt_hold", o_gnt,     4'b0100);
            chk("s4_no_tout",  o_timeout, 1'b0);
            tick();
        end
        #1;
        chk("s4_tout",     o_timeout, 1'b1);
        chk("s4_next_gnt", o_gnt,     4'b1000);
        tick();
        #1 chk("s4_tout_pulse", o_timeout, 1'b0);
        tick();

        // Reset in the middle of a packet
        do_reset();
        set_in(4'b0001, 4'b0001, 4'b0000, 1'b1, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(4'b1010, 4'b0001, 4'b0000, 1'b1, 2);
        #1;
        chk("s5_gnt",   o_gnt,   4'b0000);
        chk("s5_valid", o_valid, 1'b0);
        chk("s5_busy",  o_busy,  1'b0);
        tick();
        #1 chk("s5_regrant", o_gnt, 4'b0010);
        tick();

        // No preemption when another request rises and the owner's drops
        do_reset();
        set_in(4'b0001, 4'b0001, 4'b0000, 1'b1, 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            set_in(4'b1000, 4'b0001, (b == 2) ? 4'b0001 : 4'b0000, 1'b1, b);
            #1 chk("s6_gnt_kept", o_gnt, 4'b0001);
            tick();
        end
        #1 chk("s6_gnt_next", o_gnt, 4'b1000);
        tick();

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(199) == 0);
            i_req   = N'($urandom);
            i_valid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                i_last[k]          = ($urandom_range(3) == 0);
                i_data[k*DW +: DW] = $urandom;
            end
            i_ready = ($urandom_range(3) != 0);
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
